led_trail_pwm: RTL and testbench
================================

Name: led_trail_pwm

Overview:
- Downstream consumer of the bouncing one-hot shift register. Takes its Q vector, shift-enable tick and TC pulse.
- Renders each position as an LED whose brightness is set to full while the bit is lit and decays step by step afterwards, giving a "comet trail".
- Drives N PWM outputs. Also flags invalid (non-one-hot) input and counts completed sweeps.

Parameters:
- N, 8, number of positions/LEDs; must match the upstream register width.
- BW, 4, brightness and PWM counter width; MAX = 2^BW-1.
- DECAY, 4, brightness decrement per ena_in tick; range 1..MAX.
- FAULT_RECOVER, 3, consecutive valid ticks needed to leave FAULT; range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rsta  input  1  asynchronous reset, active-high.
- ena_in  input  1  shift tick; same signal that enables the upstream shift register.
- q_in  input  N  upstream one-hot position vector.
- tc_in  input  1  upstream 1-cycle pulse when the '1' reaches the LSB.
- led  output  N  PWM drive, one bit per position, registered.
- frame_sync  output  1  1-cycle pulse at PWM counter wrap.
- fault  output  1  high while in FAULT.
- sweep_count  output  8  number of TC pulses accepted in RUN; wraps 255->0.

Behaviour:
- Reset (rsta=1, asynchronous) forces:
  - state=IDLE; every lvl[i]=0; pwm_cnt=0; led=0; frame_sync=0; fault=0; sweep_count=0; recover_cnt=0.
- Reset mid-operation aborts immediately. No output glitch persists past the reset edge.
- valid = q_in has exactly one bit set (popcount==1). Sampled only in cycles with ena_in=1.
- FSM, all transitions on a clk edge with ena_in=1; with ena_in=0 the state holds:
  - IDLE: led forced 0, lvl held at 0. valid -> RUN and apply the lvl update for that tick. Invalid -> stay IDLE; this is not a fault.
  - RUN: invalid -> FAULT, clear all lvl to 0, recover_cnt=0. Valid -> apply the lvl update; if tc_in=1 also, sweep_count+1.
  - FAULT: fault=1, led forced 0, lvl held at 0. Valid -> recover_cnt+1; invalid -> recover_cnt=0. When recover_cnt reaches FAULT_RECOVER -> RUN, recover_cnt=0. The tick that completes recovery does not update lvl.
- lvl update, per bit i:
  - q_in[i]=1 -> lvl[i]=MAX.
  - Otherwise lvl[i] = lvl[i]-DECAY, saturating at 0. No underflow wrap.
- The lvl update happens one cycle after the tick and is visible in the next cycle.
- tc_in without ena_in is ignored. tc_in outside RUN is ignored.
- PWM:
  - pwm_cnt is free-running, +1 every clk, wraps MAX->0, independent of state.
  - led[i] <= (state==RUN) && (lvl[i] > pwm_cnt).
  - Duty = lvl[i]/2^BW. lvl=MAX gives MAX of 2^BW cycles high; lvl=0 is always off.
  - led has one cycle of latency from lvl/pwm_cnt.
- frame_sync <= (pwm_cnt==MAX): high exactly in the cycle pwm_cnt reads 0; period 2^BW cycles.
- Simultaneous ena_in, tc_in and invalid q_in in RUN: the fault wins. sweep_count does not increment.

Optional Feature:
- Macro: LED_TRAIL_TC_FLASH_EN.
- Defined: on an accepted TC in RUN (ena_in & tc_in & valid), every lvl[i] is set to max(updated lvl[i], 2^(BW-1)). The flash is 8 when BW=4. All LEDs therefore flash to at least half brightness, then decay normally.
- Undefined: tc_in affects only sweep_count. No extra logic is synthesised.

Test Plan (N=8, BW=4, DECAY=4, FAULT_RECOVER=3):
- Reset check: assert rsta mid-run with lvl nonzero -> on the same edge all outputs are 0 and state is IDLE; after release, frame_sync pulses every 16 cycles.
- Trail decay:
  - Stimulus: ena_in every 16 cycles; q_in walks 0x80,0x40,0x20,0x10,0x08.
  - Required: lvl[7] reads 15,11,7,3,0 on successive ticks.
  - Required: led[7] high 15,11,7,3,0 cycles per 16-cycle frame.
- Hold: ena_in=0 for 100 cycles with lvl[3]=7 -> lvl is unchanged and led[3] stays at 7/16 duty.
- Fault:
  - Stimulus: in RUN, ena_in with q_in=0x24 -> next cycle fault=1, led=0, all lvl=0.
  - Stimulus: then valid,valid,invalid,valid,valid,valid ticks -> RUN is re-entered only after the final valid tick.
  - Required: fault falls on that same edge.
- Sweep counting:
  - Stimulus: 256 accepted TC pulses -> sweep_count wraps to 0.
  - Stimulus: tc_in with ena_in=0, or tc_in in FAULT -> no increment.
- LED_TRAIL_TC_FLASH_EN:
  - Stimulus: lvl all 3, then tick with q_in=0x01, tc_in=1.
  - Required: lvl[0]=15 and all others 8.
  - Required with the macro undefined: lvl[0]=15 and all others 0.

Source files
------------

// File: rtl/led_trail_pwm.sv
// ---------------------------------------------------------------------------
// led_trail_pwm
//
// Comet-trail LED renderer. It sits downstream of a bouncing one-hot shift
// register. On every shift tick (ena_in) the lit position is set to full
// brightness. Every other position fades by DECAY, saturating at zero. Each
// position is rendered as a PWM output that a free-running counter compares
// against the position's brightness level.
//
// The block also detects input that is not one-hot and counts completed sweeps.
//
// Ports:
//   clk          in   system clock, rising edge
//   rsta         in   asynchronous reset, active-high
//   ena_in       in   shift tick (same enable as the upstream register)
//   q_in[N]      in   upstream one-hot position vector
//   tc_in        in   upstream pulse when the '1' reaches the LSB
//   led[N]       out  registered PWM drive, one bit per position
//   frame_sync   out  1-cycle pulse in the cycle the PWM counter reads 0
//   fault        out  high while the input is considered corrupt
//   sweep_count  out  accepted TC pulses in RUN, wraps 255->0
//
// Optional feature macro: LED_TRAIL_TC_FLASH_EN
//   When this macro is defined, an accepted TC raises every level to at least
//   half brightness, so the whole bar flashes once per sweep.
// ---------------------------------------------------------------------------
module led_trail_pwm #(
    parameter int N             = 8,
    parameter int BW            = 4,
    parameter int DECAY         = 4,
    parameter int FAULT_RECOVER = 3
) (
    input  logic         clk,
    input  logic         rsta,
    input  logic         ena_in,
    input  logic [N-1:0] q_in,
    input  logic         tc_in,
    output logic [N-1:0] led,
    output logic         frame_sync,
    output logic         fault,
    output logic [7:0]   sweep_count
);

    localparam logic [BW-1:0] MAX          = {BW{1'b1}};
    localparam logic [BW-1:0] DECAY_STEP   = BW'(DECAY);
    localparam logic [3:0]    RECOVER_LAST = 4'(FAULT_RECOVER - 1);
`ifdef LED_TRAIL_TC_FLASH_EN
    localparam logic [BW-1:0] FLASH_LVL    = BW'(1 << (BW - 1));
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [N-1:0][BW-1:0] lvl_q, lvl_d;
    logic [BW-1:0]        pwm_cnt_q, pwm_cnt_d;
    logic [N-1:0]         led_q, led_d;
    logic                 frame_sync_q, frame_sync_d;
    logic [7:0]           sweep_count_q, sweep_count_d;
    logic [3:0]           recover_cnt_q, recover_cnt_d;

    logic valid;
    logic lvl_step;
    logic lvl_clear;
    logic led_en;

    // Exactly one bit is set: the vector is non-zero and clearing its lowest
    // set bit leaves nothing.
    assign valid = (q_in != '0) && ((q_in & (q_in - N'(1))) == '0);

    always_comb begin
        state_d       = state_q;
        recover_cnt_d = recover_cnt_q;
        sweep_count_d = sweep_count_q;
        lvl_step      = 1'b0;
        lvl_clear     = 1'b0;

        if (ena_in) begin
            case (state_q)
                IDLE: begin
                    // A bad vector before the first good one is just start-up noise.
                    if (valid) begin
                        state_d  = RUN;
                        lvl_step = 1'b1;
                    end
                end
                RUN: begin
                    // An invalid vector wins over a simultaneous TC.
                    if (!valid) begin
                        state_d       = FAULT;
                        lvl_clear     = 1'b1;
                        recover_cnt_d = '0;
                    end else begin
                        lvl_step = 1'b1;
                        if (tc_in) begin
                            sweep_count_d = sweep_count_q + 8'd1;
                        end
                    end
                end
                FAULT: begin
                    if (!valid) begin
                        recover_cnt_d = '0;
                    end else if (recover_cnt_q == RECOVER_LAST) begin
                        // The recovering tick only changes state; the trail
                        // restarts from dark on the next tick.
                        state_d       = RUN;
                        recover_cnt_d = '0;
                    end else begin
                        recover_cnt_d = recover_cnt_q + 4'd1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        pwm_cnt_d    = pwm_cnt_q + BW'(1);
        frame_sync_d = (pwm_cnt_q == MAX);
        // LEDs are blanked on the edge that enters FAULT as well, so the
        // outputs go dark in the same cycle that fault rises.
        led_en       = (state_q == RUN) && (state_d == RUN);
    end

`ifdef LED_TRAIL_TC_FLASH_EN
    logic tc_flash;
    assign tc_flash = ena_in && (state_q == RUN) && valid && tc_in;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_pos
            logic [BW-1:0] decayed;
            logic [BW-1:0] stepped;
            logic [BW-1:0] lvl_new;

            assign decayed = (lvl_q[gi] >= DECAY_STEP) ? (lvl_q[gi] - DECAY_STEP) : '0;
            assign stepped = q_in[gi] ? MAX : decayed;
`ifdef LED_TRAIL_TC_FLASH_EN
            assign lvl_new = (tc_flash && (stepped < FLASH_LVL)) ? FLASH_LVL : stepped;
`else
            assign lvl_new = stepped;
`endif
            assign lvl_d[gi] = lvl_clear ? '0 : (lvl_step ? lvl_new : lvl_q[gi]);
            assign led_d[gi] = led_en && (lvl_q[gi] > pwm_cnt_q);
        end
    endgenerate

    always_ff @(posedge clk or posedge rsta) begin
        if (rsta) begin
            state_q       <= IDLE;
            lvl_q         <= '0;
            pwm_cnt_q     <= '0;
            led_q         <= '0;
            frame_sync_q  <= 1'b0;
            sweep_count_q <= '0;
            recover_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            lvl_q         <= lvl_d;
            pwm_cnt_q     <= pwm_cnt_d;
            led_q         <= led_d;
            frame_sync_q  <= frame_sync_d;
            sweep_count_q <= sweep_count_d;
            recover_cnt_q <= recover_cnt_d;
        end
    end

    assign led         = led_q;
    assign frame_sync  = frame_sync_q;
    assign fault       = (state_q == FAULT);
    assign sweep_count = sweep_count_q;

endmodule

// File: tb/tb_led_trail_pwm.sv
// ---------------------------------------------------------------------------
// tb_led_trail_pwm
//
// Directed bench for led_trail_pwm (N=8, BW=4, DECAY=4, FAULT_RECOVER=3).
//
// The bench has no view of the brightness levels. It reads them back through
// the LED duty instead: over 16 consecutive cycles with no tick, LED i is high
// for exactly lvl[i] cycles. Expected duties are packed one byte per LED,
// with LED 7 in the top byte.
// ---------------------------------------------------------------------------
module tb_led_trail_pwm;

    logic       clk = 1'b0;
    logic       rsta = 1'b0;
    logic       ena_in = 1'b0;
    logic [7:0] q_in = 8'h00;
    logic       tc_in = 1'b0;
    logic [7:0] led;
    logic       frame_sync;
    logic       fault;
    logic [7:0] sweep_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    led_trail_pwm #(
        .N(8), .BW(4), .DECAY(4), .FAULT_RECOVER(3)
    ) dut (
        .clk(clk),
        .rsta(rsta),
        .ena_in(ena_in),
        .q_in(q_in),
        .tc_in(tc_in),
        .led(led),
        .frame_sync(frame_sync),
        .fault(fault),
        .sweep_count(sweep_count)
    );

    typedef struct {
        logic [7:0]  q;
        logic        tc;
        int          pre_idle;
        logic        exp_fault;
        logic [7:0]  exp_sweep;
        logic [63:0] exp_duty;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Called at posedge+1. This is one tick cycle, and it returns at posedge+1
    // right after the tick edge.
    task automatic do_tick(input logic [7:0] q, input logic tc);
        ena_in = 1'b1;
        q_in   = q;
        tc_in  = tc;
        @(posedge clk); #1;
        ena_in = 1'b0;
        tc_in  = 1'b0;
    endtask

    task automatic measure(output logic [63:0] duty);
        duty = '0;
        for (int k = 0; k < 16; k++) begin
            @(posedge clk); #1;
            for (int b = 0; b < 8; b++) begin
                if (led[b]) duty[b*8 +: 8] = duty[b*8 +: 8] + 8'd1;
            end
        end
    endtask

    // Find a frame_sync pulse, then measure the distance to the next pulse.
    task automatic check_frame_period(input string name);
        int   period;
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(posedge clk); #1;
            if (frame_sync) seen = 1'b1;
        end
        check({name, "_seen"}, 64'(seen), 64'd1);
        period = 0;
        for (int k = 1; k <= 40 && period == 0; k++) begin
            @(posedge clk); #1;
            if (frame_sync) period = k;
        end
        check({name, "_period"}, 64'(period), 64'd16);
        $display("frame_sync period=%0d", period);
    endtask

    initial begin
        logic [63:0] duty;

        // q, tc, idle cycles before measuring, fault, sweep, duty per LED (LED7..LED0)
        vecs[0]  = '{8'h00, 1'b0, 0,   1'b0, 8'd0, 64'h0000_0000_0000_0000}; // IDLE: zero vector ignored
        vecs[1]  = '{8'h03, 1'b1, 0,   1'b0, 8'd0, 64'h0000_0000_0000_0000}; // IDLE: two bits, no fault, no count
        vecs[2]  = '{8'h80, 1'b0, 0,   1'b0, 8'd0, 64'h0F00_0000_0000_0000}; // enter RUN
        vecs[3]  = '{8'h40, 1'b0, 0,   1'b0, 8'd0, 64'h0B0F_0000_0000_0000};
        vecs[4]  = '{8'h20, 1'b0, 0,   1'b0, 8'd0, 64'h070B_0F00_0000_0000};
        vecs[5]  = '{8'h10, 1'b0, 0,   1'b0, 8'd0, 64'h0307_0B0F_0000_0000};
        vecs[6]  = '{8'h08, 1'b0, 0,   1'b0, 8'd0, 64'h0003_070B_0F00_0000}; // LED7 reaches 0
        vecs[7]  = '{8'h04, 1'b0, 0,   1'b0, 8'd0, 64'h0000_0307_0B0F_0000};
        vecs[8]  = '{8'h02, 1'b0, 100, 1'b0, 8'd0, 64'h0000_0003_070B_0F00}; // hold: lvl[3]=7 after 100 cycles
`ifdef LED_TRAIL_TC_FLASH_EN
        vecs[9]  = '{8'h01, 1'b1, 0,   1'b0, 8'd1, 64'h0808_0808_0808_0B0F}; // TC flash floor of 8
        vecs[10] = '{8'h02, 1'b0, 0,   1'b0, 8'd1, 64'h0404_0404_0404_0F0B};
`else
        vecs[9]  = '{8'h01, 1'b1, 0,   1'b0, 8'd1, 64'h0000_0000_0307_0B0F}; // TC only counts
        vecs[10] = '{8'h02, 1'b0, 0,   1'b0, 8'd1, 64'h0000_0000_0003_0F0B};
`endif
        vecs[11] = '{8'h24, 1'b1, 0,   1'b1, 8'd1, 64'h0000_0000_0000_0000}; // invalid + TC: fault wins
        vecs[12] = '{8'h01, 1'b1, 0,   1'b1, 8'd1, 64'h0000_0000_0000_0000}; // valid 1, TC in FAULT ignored
        vecs[13] = '{8'h02, 1'b0, 0,   1'b1, 8'd1, 64'h0000_0000_0000_0000}; // valid 2
        vecs[14] = '{8'h00, 1'b0, 0,   1'b1, 8'd1, 64'h0000_0000_0000_0000}; // invalid resets count
        vecs[15] = '{8'h04, 1'b0, 0,   1'b1, 8'd1, 64'h0000_0000_0000_0000}; // valid 1
        vecs[16] = '{8'h08, 1'b1, 0,   1'b1, 8'd1, 64'h0000_0000_0000_0000}; // valid 2, TC ignored
        vecs[17] = '{8'h10, 1'b0, 0,   1'b0, 8'd1, 64'h0000_0000_0000_0000}; // valid 3: back to RUN, no lvl update
        vecs[18] = '{8'h20, 1'b1, 0,   1'b0, 8'd2, 64'h0000_0F00_0000_0000}; // first RUN tick after recovery

        // Power-on reset
        #1 rsta = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_led",   64'(led),         64'd0);
        check("rst_fs",    64'(frame_sync),  64'd0);
        check("rst_fault", 64'(fault),       64'd0);
        check("rst_sweep", 64'(sweep_count), 64'd0);
        @(posedge clk); #1;
        rsta = 1'b0;
        check_frame_period("fs_after_por");

        // Table-driven ticks
        for (int i = 0; i < NV; i++) begin
            do_tick(vecs[i].q, vecs[i].tc);
            check($sformatf("v%0d_fault", i), 64'(fault), 64'(vecs[i].exp_fault));
            if (vecs[i].exp_fault) check($sformatf("v%0d_led_dark", i), 64'(led), 64'd0);
            repeat (vecs[i].pre_idle) @(posedge clk);
            if (vecs[i].pre_idle > 0) #1;
            measure(duty);
            check($sformatf("v%0d_duty", i),  duty,              vecs[i].exp_duty);
            check($sformatf("v%0d_sweep", i), 64'(sweep_count),  64'(vecs[i].exp_sweep));
            $display("vec %0d q=%02h tc=%b fault=%b sweep=%0d duty=%016h",
                     i, vecs[i].q, vecs[i].tc, fault, sweep_count, duty);
        end

        // tc_in without ena_in must not count
        tc_in = 1'b1;
        q_in  = 8'h01;
        repeat (20) @(posedge clk);
        #1;
        tc_in = 1'b0;
        check("tc_no_ena_sweep", 64'(sweep_count), 64'd2);
        $display("tc without ena: sweep=%0d", sweep_count);

        // Sweep counter wrap: 253 more accepted TCs reach 255, one more wraps to 0
        for (int k = 0; k < 253; k++) do_tick(8'h01, 1'b1);
        check("sweep_255", 64'(sweep_count), 64'd255);
        $display("sweep before wrap=%0d", sweep_count);
        do_tick(8'h01, 1'b1);
        check("sweep_wrap", 64'(sweep_count), 64'd0);
        $display("sweep after wrap=%0d", sweep_count);

        // Asynchronous reset mid-run with lvl[0]=15
        @(negedge clk); #2;
        rsta = 1'b1;
        #1;
        check("arst_led",   64'(led),         64'd0);
        check("arst_fs",    64'(frame_sync),  64'd0);
        check("arst_fault", 64'(fault),       64'd0);
        check("arst_sweep", 64'(sweep_count), 64'd0);
        $display("async reset: led=%02h fs=%b fault=%b sweep=%0d", led, frame_sync, fault, sweep_count);
        repeat (2) @(posedge clk);
        #1;
        rsta = 1'b0;
        check_frame_period("fs_after_arst");

        // Back in IDLE, an invalid tick is not a fault and leaves the LEDs dark
        do_tick(8'h41, 1'b0);
        check("idle_inv_fault", 64'(fault), 64'd0);
        measure(duty);
        check("idle_inv_duty", duty, 64'h0);
        // The first valid tick starts a fresh trail; nothing is left from before the reset.
        do_tick(8'h80, 1'b1);
        measure(duty);
        check("restart_duty",  duty,             64'h0F00_0000_0000_0000);
        check("restart_sweep", 64'(sweep_count), 64'd0);
        $display("restart: duty=%016h sweep=%0d", duty, sweep_count);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
